// File: rtl/starship_reset_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : starship_reset_sequencer
//  Purpose  : Power-up and runtime reset sequencer for a MIG DDR3-backed SoC.
//             It holds the MIG in reset, waits for clock lock and DDR3
//             calibration, then releases the debug domain and, after a
//             stagger, the core. At runtime it handles debug-module
//             non-debug resets, fuzzing meta-reset strobes and loss of
//             lock/calibration. A calibration timeout parks the block in a
//             terminal FAIL state.
//  Ports    : clock               - single clock, rising edge
//             reset_n             - asynchronous active-low reset
//             mmcm_locked         - MIG clock-manager lock status
//             init_calib_complete - MIG DDR3 calibration done
//             ndreset             - debug-module non-debug reset request
//             meta_req            - one-cycle meta-reset request pulse
//             mig_sys_rst         - active-high MIG system reset
//             debug_reset         - active-high debug-domain reset
//             core_reset          - active-high core/SoC reset
//             meta_reset          - active-high meta-reset strobe
//             fail                - sticky calibration-timeout flag
//             state               - current state encoding (3 bits)
//             restart_count       - saturating lock/calibration-loss count
//  Revision : 1.0 - initial release
// ============================================================================
module starship_reset_sequencer #(
  parameter int HOLD_CYCLES    = 16,       // >= 2
  parameter int STAGGER_CYCLES = 8,        // >= 1
  parameter int CALIB_TIMEOUT  = 1000000,  // >= 2
  parameter int CNT_W          = 24        // must hold the largest of the above
) (
  input  logic       clock,
  input  logic       reset_n,
  input  logic       mmcm_locked,
  input  logic       init_calib_complete,
  input  logic       ndreset,
  input  logic       meta_req,
  output logic       mig_sys_rst,
  output logic       debug_reset,
  output logic       core_reset,
  output logic       meta_reset,
  output logic       fail,
  output logic [2:0] state,
  output logic [7:0] restart_count
);

  typedef enum logic [2:0] {
    S_HOLD       = 3'd0,
    S_WAIT_CALIB = 3'd1,
    S_DEBUG_REL  = 3'd2,
    S_RUN        = 3'd3,
    S_CORE_HOLD  = 3'd4,
    S_META       = 3'd5,
    S_FAIL       = 3'd6
  } state_t;

  localparam logic [CNT_W-1:0] c_hold_last    = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_stagger_last = CNT_W'(STAGGER_CYCLES - 1);
  localparam logic [CNT_W-1:0] c_calib_last   = CNT_W'(CALIB_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] c_cnt_one      = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_cnt_max      = {CNT_W{1'b1}};
  localparam logic [7:0]       c_restart_max  = 8'hFF;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [7:0]       r_restart_count;
  logic             r_mig_sys_rst;
  logic             r_debug_reset;
  logic             r_core_reset;
  logic             r_meta_reset;
  logic             r_fail;

  state_t           w_next_state;
  logic             w_link_ok;
  logic             w_link_lost;

  assign w_link_ok = mmcm_locked & init_calib_complete;

  // Next-state selection. Link loss is checked first in every post-calibration
  // state so that a dropped lock always wins over local sequencing.
  always_comb begin
    w_next_state = r_state;
    w_link_lost  = 1'b0;
    case (r_state)
      S_HOLD: begin
        if (r_cnt == c_hold_last) w_next_state = S_WAIT_CALIB;
      end
      S_WAIT_CALIB: begin
        // Calibration completing in the timeout cycle takes precedence.
        if (w_link_ok)                  w_next_state = S_DEBUG_REL;
        else if (r_cnt == c_calib_last) w_next_state = S_FAIL;
      end
      S_DEBUG_REL: begin
        if (!w_link_ok) begin
          w_next_state = S_HOLD;
          w_link_lost  = 1'b1;
        end else if (r_cnt == c_stagger_last) begin
          w_next_state = S_RUN;
        end
      end
      S_RUN: begin
        if (!w_link_ok) begin
          w_next_state = S_HOLD;
          w_link_lost  = 1'b1;
        end else if (ndreset) begin
          w_next_state = S_CORE_HOLD;
        end else if (meta_req) begin
          w_next_state = S_META;
        end
      end
      S_CORE_HOLD: begin
        // Minimum hold length is enforced, then the core stays in reset for
        // as long as the debug module keeps ndreset asserted.
        if (!w_link_ok) begin
          w_next_state = S_HOLD;
          w_link_lost  = 1'b1;
        end else if ((r_cnt >= c_hold_last) && !ndreset) begin
          w_next_state = S_RUN;
        end
      end
      S_META: begin
        if (!w_link_ok) begin
          w_next_state = S_HOLD;
          w_link_lost  = 1'b1;
        end else if (r_cnt == c_hold_last) begin
          w_next_state = S_RUN;
        end
      end
      S_FAIL: begin
        w_next_state = S_FAIL;
      end
      default: begin
        // Unused encoding 7 recovers through a fresh reset hold.
        w_next_state = S_HOLD;
      end
    endcase
  end

  // All state, counter and outputs update together; outputs are decoded from
  // the next state so they change on the same edge as the state itself.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state         <= S_HOLD;
      r_cnt           <= '0;
      r_restart_count <= '0;
      r_mig_sys_rst   <= 1'b1;
      r_debug_reset   <= 1'b1;
      r_core_reset    <= 1'b1;
      r_meta_reset    <= 1'b0;
      r_fail          <= 1'b0;
    end else begin
      r_state <= w_next_state;

      // Counter restarts on every state change and saturates so a very long
      // ndreset in CORE_HOLD cannot wrap it back below the hold threshold.
      if (w_next_state != r_state) begin
        r_cnt <= '0;
      end else if (r_cnt != c_cnt_max) begin
        r_cnt <= r_cnt + c_cnt_one;
      end

      if (w_link_lost && (r_restart_count != c_restart_max)) begin
        r_restart_count <= r_restart_count + 8'd1;
      end

      r_mig_sys_rst <= (w_next_state == S_HOLD);
      r_debug_reset <= (w_next_state == S_HOLD) ||
                       (w_next_state == S_WAIT_CALIB) ||
                       (w_next_state == S_FAIL);
      r_core_reset  <= (w_next_state != S_RUN);
      r_meta_reset  <= (w_next_state == S_META);
      r_fail        <= (w_next_state == S_FAIL);
    end
  end

  assign state         = r_state;
  assign restart_count = r_restart_count;
  assign mig_sys_rst   = r_mig_sys_rst;
  assign debug_reset   = r_debug_reset;
  assign core_reset    = r_core_reset;
  assign meta_reset    = r_meta_reset;
  assign fail          = r_fail;

endmodule
`default_nettype wire

// File: doc/starship_reset_sequencer.md
STARSHIP_RESET_SEQUENCER -- requirements
Module: starship_reset_sequencer

Interface
REQ-001 Parameter HOLD_CYCLES, default 16: reset-assertion hold length in cycles, legal range >=2.
REQ-002 Parameter STAGGER_CYCLES, default 8: cycles between debug-domain release and core release, legal range >=1.
REQ-003 Parameter CALIB_TIMEOUT, default 1000000: maximum cycles allowed for DDR3 lock/calibration, legal range >=2.
REQ-004 Parameter CNT_W, default 24: internal counter width; it SHALL hold max(HOLD_CYCLES, STAGGER_CYCLES, CALIB_TIMEOUT).
REQ-005 Port clock, input, 1: the single clock; all state updates on its rising edge.
REQ-006 Port reset_n, input, 1: asynchronous, active-low reset.
REQ-007 Port mmcm_locked, input, 1: MIG clock-manager lock status.
REQ-008 Port init_calib_complete, input, 1: MIG DDR3 calibration done.
REQ-009 Port ndreset, input, 1: debug-module non-debug reset request, level.
REQ-010 Port meta_req, input, 1: single-cycle pulse requesting a fuzzing meta-reset.
REQ-011 Port mig_sys_rst, output, 1: active-high MIG system reset.
REQ-012 Port debug_reset, output, 1: active-high debug-domain reset.
REQ-013 Port core_reset, output, 1: active-high core/SoC reset.
REQ-014 Port meta_reset, output, 1: active-high meta-reset strobe to the SoC coverage logic.
REQ-015 Port fail, output, 1: sticky calibration-timeout flag.
REQ-016 Port state, output, 3: current state encoding.
REQ-017 Port restart_count, output, 8: count of lock/calibration-loss restarts, saturating at 255.

Function
REQ-018 States and encodings SHALL be: HOLD=0, WAIT_CALIB=1, DEBUG_REL=2, RUN=3, CORE_HOLD=4, META=5, FAIL=6; encoding 7 SHALL go to HOLD on the next edge.
REQ-019 All outputs SHALL be registered and take their new values on the same edge as the state change.
REQ-020 Output decode: mig_sys_rst=1 only in HOLD; debug_reset=1 in HOLD, WAIT_CALIB and FAIL; core_reset=0 only in RUN; meta_reset=1 only in META.
REQ-021 Entering HOLD, DEBUG_REL, CORE_HOLD, META or WAIT_CALIB SHALL clear the counter; the counter SHALL increment by 1 every cycle in those states.
REQ-022 HOLD SHALL go to WAIT_CALIB when counter == HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles of mig_sys_rst=1.
REQ-023 WAIT_CALIB SHALL go to DEBUG_REL in the first cycle where mmcm_locked && init_calib_complete are sampled high.
REQ-024 WAIT_CALIB SHALL go to FAIL when counter == CALIB_TIMEOUT-1 and calibration is not complete; calibration completing in that same cycle wins.
REQ-025 DEBUG_REL SHALL go to RUN when counter == STAGGER_CYCLES-1.
REQ-026 In DEBUG_REL, RUN, CORE_HOLD and META, a sampled low on mmcm_locked or init_calib_complete SHALL go to HOLD and increment restart_count, saturating at 255.
REQ-027 RUN priority SHALL be: lock/calibration loss > ndreset=1 (go to CORE_HOLD) > meta_req=1 (go to META).
REQ-028 CORE_HOLD SHALL go to RUN when counter >= HOLD_CYCLES-1 and ndreset=0; if ndreset is still high, the state SHALL remain CORE_HOLD.
REQ-029 META SHALL go to RUN when counter == HOLD_CYCLES-1, giving exactly HOLD_CYCLES cycles of meta_reset=1 with core_reset=1.
REQ-030 meta_req SHALL be ignored in every state except RUN and SHALL NOT be latched.
REQ-031 FAIL SHALL be terminal: fail=1 and all resets asserted except mig_sys_rst=0; only reset_n SHALL exit FAIL.

Reset
REQ-032 While reset_n=0, the block SHALL immediately and asynchronously set: state=HOLD, counter=0, mig_sys_rst=1, debug_reset=1, core_reset=1, meta_reset=0, fail=0, restart_count=0.
REQ-033 Deassertion of reset_n SHALL take effect on the first rising edge of clock; reset_n asserted mid-sequence, including in FAIL, SHALL restart from HOLD.

Verification (HOLD_CYCLES=4, STAGGER_CYCLES=2, CALIB_TIMEOUT=32)
REQ-034 Power-up: release reset_n, with lock and calibration already high -> mig_sys_rst=1 for 4 cycles; 1 cycle in WAIT_CALIB; debug_reset falls; core_reset falls 2 cycles later; state=3.
REQ-035 Timeout: hold init_calib_complete=0 -> after 32 cycles in WAIT_CALIB, state=6 and fail=1; fail stays 1 until reset_n pulses low.
REQ-036 Meta-reset: 1-cycle meta_req in RUN -> meta_reset=1 and core_reset=1 for exactly 4 cycles; debug_reset stays 0; return to state=3; a meta_req during META is ignored.
REQ-037 ndreset held for 10 cycles in RUN -> core_reset=1 until the cycle after ndreset falls, debug_reset=0 throughout; ndreset and meta_req in the same cycle -> CORE_HOLD.
REQ-038 Drop mmcm_locked for 1 cycle in RUN -> state=0, mig_sys_rst=1, restart_count increments; 256 such drops -> restart_count=255.
